// File: rtl/text_pkg.sv
// Shared definitions for the text-mode scan path: cell geometry, default
// screen size, the clear-sequencer states and the glyph bit selector.
package text_pkg;

    localparam int CELL_W   = 8;
    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 60;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLANK = 2'd1,
        CLEAR      = 2'd2,
        DONE       = 2'd3
    } clr_state_t;

    // Row sr sits in pixels[8*sr+7 : 8*sr] with bit 7 the leftmost pixel,
    // so column sc maps to bit 7-sc of that row, i.e. index {sr, ~sc}.
    function automatic logic glyph_bit(input logic [63:0] pixels,
                                       input logic [2:0]  sr,
                                       input logic [2:0]  sc);
        logic [5:0] idx;
        idx = {sr, ~sc};
        return pixels[idx];
    endfunction

endpackage

// File: rtl/text_clear_fsm.sv
// Screen-clear sequencer: accepts a fill request, waits for vertical blank,
// then walks the whole character buffer writing the latched fill code. The
// walk pauses (counter held) whenever the beam re-enters the visible rows.
module text_clear_fsm
    import text_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int HV_W   = 10,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HV_W-1:0]   vcount_i,
    input  logic              clear_req_i,
    input  logic [7:0]        fill_code_i,
    output logic              active_o,
    output logic              wr_req_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int LAST_CELL = COLS * ROWS - 1;
    localparam int V_VIS     = ROWS * CELL_W;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        fill_q, fill_d;
    logic              in_vblank;

    assign in_vblank = (vcount_i >= HV_W'(V_VIS));

    // State, address counter and fill-code latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    // Next state; the write strobe is gated by the live vcount so a pause
    // never issues a write into the visible region
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        wr_req_o = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req_i) begin
                    fill_d  = fill_code_i;
                    state_d = WAIT_BLANK;
                end
            end
            WAIT_BLANK: begin
                if (in_vblank) state_d = CLEAR;
            end
            CLEAR: begin
                if (!in_vblank) begin
                    state_d = WAIT_BLANK;
                end else begin
                    wr_req_o = 1'b1;
                    if (cnt_q == ADDR_W'(LAST_CELL)) state_d = DONE;
                    else                             cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign active_o  = (state_q == CLEAR);
    assign wr_addr_o = cnt_q;
    assign wr_data_o = fill_q;
    assign busy_o    = (state_q == WAIT_BLANK) || (state_q == CLEAR);

endmodule

// File: rtl/text_scan_ctrl.sv
// Text-mode render sequencer: beam position -> buffer address -> glyph
// code -> pixel, with syncs and display-enable delayed to match (3 clocks).
// Owns the buffer write port for the vblank screen clear.
// Optional blinking cursor: define TEXT_CURSOR_EN.
module text_scan_ctrl
    import text_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int HV_W   = 10,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HV_W-1:0]   hcount,
    input  logic [HV_W-1:0]   vcount,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [ADDR_W-1:0] char_addr,
    output logic              char_rd_en,
    input  logic [7:0]        char_data,
    output logic              char_we,
    output logic [7:0]        char_wdata,
    output logic [7:0]        glyph_code,
    input  logic [63:0]       glyph_pixels,
    input  logic              clear_req,
    input  logic [7:0]        fill_code,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              pixel_on,
    output logic              de_out,
    output logic              hsync_out,
    output logic              vsync_out
`ifdef TEXT_CURSOR_EN
    ,
    input  logic [6:0]        cursor_col,
    input  logic [5:0]        cursor_row
`endif
);

    localparam int H_VIS = COLS * CELL_W;
    localparam int V_VIS = ROWS * CELL_W;

    logic              visible;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] addr_p1_q;
    logic              rd_en_p1_q;
    logic [2:0]        sr_p1_q, sc_p1_q, sr_p2_q, sc_p2_q;
    logic [2:0]        de_q, hs_q, vs_q;
    logic              pixel_q, pixel_d;
    logic              cursor_inv;
    logic              clr_active, clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [7:0]        clr_wdata;

    // Beam position to visibility and row-major cell address
    always_comb begin
        visible   = (hcount < HV_W'(H_VIS)) && (vcount < HV_W'(V_VIS));
        scan_addr = ADDR_W'(vcount[HV_W-1:3]) * ADDR_W'(COLS)
                  + ADDR_W'(hcount[HV_W-1:3]);
    end

    // Stage 1 address/offsets, stage 2 offsets, 3-deep sync/enable delay
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_p1_q  <= '0;
            rd_en_p1_q <= 1'b0;
            sr_p1_q    <= '0;
            sc_p1_q    <= '0;
            sr_p2_q    <= '0;
            sc_p2_q    <= '0;
            de_q       <= '0;
            hs_q       <= '0;
            vs_q       <= '0;
        end else begin
            addr_p1_q  <= scan_addr;
            rd_en_p1_q <= visible;
            sr_p1_q    <= vcount[2:0];
            sc_p1_q    <= hcount[2:0];
            sr_p2_q    <= sr_p1_q;
            sc_p2_q    <= sc_p1_q;
            de_q       <= {de_q[1:0], visible};
            hs_q       <= {hs_q[1:0], hsync_in};
            vs_q       <= {vs_q[1:0], vsync_in};
        end
    end

`ifdef TEXT_CURSOR_EN
    logic [5:0] frame_q;
    logic       vs_prev_q;
    logic       hit_p1_q, hit_p2_q;

    // Frame counter for blink phase; cursor-cell match travels with the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q   <= '0;
            vs_prev_q <= 1'b0;
            hit_p1_q  <= 1'b0;
            hit_p2_q  <= 1'b0;
        end else begin
            frame_q   <= frame_q + 6'(vsync_in & ~vs_prev_q);
            vs_prev_q <= vsync_in;
            hit_p1_q  <= (hcount[HV_W-1:3] == (HV_W-3)'(cursor_col))
                      && (vcount[HV_W-1:3] == (HV_W-3)'(cursor_row));
            hit_p2_q  <= hit_p1_q;
        end
    end

    assign cursor_inv = hit_p2_q & frame_q[5];
`else
    assign cursor_inv = 1'b0;
`endif

    assign glyph_code = char_data;
    assign pixel_d    = de_q[1] & (glyph_bit(glyph_pixels, sr_p2_q, sc_p2_q) ^ cursor_inv);

    // Stage 3: glyph pixel registered alongside the delayed enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pixel_q <= 1'b0;
        else     pixel_q <= pixel_d;
    end

    text_clear_fsm #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .HV_W   (HV_W),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk         (clk),
        .rst         (rst),
        .vcount_i    (vcount),
        .clear_req_i (clear_req),
        .fill_code_i (fill_code),
        .active_o    (clr_active),
        .wr_req_o    (clr_we),
        .wr_addr_o   (clr_addr),
        .wr_data_o   (clr_wdata),
        .busy_o      (clear_busy),
        .done_o      (clear_done)
    );

    // Clear only runs in vblank, where the scan never reads
    assign char_addr  = clr_active ? clr_addr : addr_p1_q;
    assign char_rd_en = rd_en_p1_q;
    assign char_we    = clr_we;
    assign char_wdata = clr_wdata;
    assign pixel_on   = pixel_q;
    assign de_out     = de_q[2];
    assign hsync_out  = hs_q[2];
    assign vsync_out  = vs_q[2];

endmodule

// File: tb/tb_text_scan_ctrl.sv
// Bench for text_scan_ctrl: behavioural character buffer and glyph decoder,
// scoreboard of expected read strobes and video outputs, and a write-port
// monitor for the screen-clear sequencer.
`timescale 1ns/1ps
module tb_text_scan_ctrl;

    localparam int COLS = 80, ROWS = 60, HV_W = 10, ADDR_W = 13;
    localparam int NCELL = COLS * ROWS;

    logic              clk = 1'b0;
    logic              rst;
    logic [HV_W-1:0]   hcount, vcount;
    logic              hsync_in, vsync_in;
    logic [ADDR_W-1:0] char_addr;
    logic              char_rd_en;
    logic [7:0]        char_data = 8'd0;
    logic              char_we;
    logic [7:0]        char_wdata;
    logic [7:0]        glyph_code;
    logic [63:0]       glyph_pixels;
    logic              clear_req;
    logic [7:0]        fill_code;
    logic              clear_busy, clear_done;
    logic              pixel_on, de_out, hsync_out, vsync_out;

    logic              pl_we;
    logic [ADDR_W-1:0] pl_addr;
    logic [7:0]        pl_data;
    logic [7:0]        mem [0:NCELL-1];

    typedef struct packed { int due; logic pix; logic de; logic hs; logic vs; } px_t;
    typedef struct packed { int due; logic en; logic [ADDR_W-1:0] addr; } rd_t;
    px_t pxq[$];
    rd_t rdq[$];

    int n_chk = 0, n_err = 0, cyc = 0;
    int wr_cnt = 0, done_cnt = 0, exp_wr_addr = 0;
    logic armed = 1'b0;
    logic [7:0] exp_fill = 8'd0;

    always #5 clk = ~clk;

    text_scan_ctrl #(.COLS(COLS), .ROWS(ROWS), .HV_W(HV_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .char_addr(char_addr), .char_rd_en(char_rd_en), .char_data(char_data),
        .char_we(char_we), .char_wdata(char_wdata),
        .glyph_code(glyph_code), .glyph_pixels(glyph_pixels),
        .clear_req(clear_req), .fill_code(fill_code),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .pixel_on(pixel_on), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
`ifdef TEXT_CURSOR_EN
        , .cursor_col(7'd127), .cursor_row(6'd63)
`endif
    );

    // Character buffer: one-cycle read latency, shared address
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (char_we && char_addr < ADDR_W'(NCELL)) mem[char_addr] <= char_wdata;
        if (char_rd_en && char_addr < ADDR_W'(NCELL)) char_data <= mem[char_addr];
    end

    function automatic logic [7:0] grow(input logic [7:0] c, input logic [2:0] r);
        logic [7:0] rr;
        rr = {5'd0, r};
        return (c * 8'h38) ^ (rr * 8'h11) ^ 8'h11;
    endfunction

    function automatic logic [63:0] gpix(input logic [7:0] c);
        logic [63:0] p;
        for (int r = 0; r < 8; r++) p[8*r +: 8] = grow(c, 3'(r));
        return p;
    endfunction

    assign glyph_pixels = gpix(glyph_code);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: score due outputs, drive new inputs, predict, watch writes
    task automatic step(input int h, input int v, input logic hs, input logic vs,
                        input logic req, input logic [7:0] fill);
        px_t pe;
        rd_t re;
        logic vis;
        logic [7:0] row;
        int a;
        @(negedge clk);
        cyc++;
        while (rdq.size() > 0 && rdq[0].due <= cyc) begin
            re = rdq.pop_front();
            check_eq("rd_en", 32'(char_rd_en), 32'(re.en));
            if (re.en) check_eq("rd_addr", 32'(char_addr), 32'(re.addr));
        end
        while (pxq.size() > 0 && pxq[0].due <= cyc) begin
            pe = pxq.pop_front();
            check_eq("pixel_on", 32'(pixel_on), 32'(pe.pix));
            check_eq("de_out", 32'(de_out), 32'(pe.de));
            check_eq("hsync_out", 32'(hsync_out), 32'(pe.hs));
            check_eq("vsync_out", 32'(vsync_out), 32'(pe.vs));
        end
        if (clear_done) begin
            done_cnt++;
            armed = 1'b0;
        end
        hcount = HV_W'(h); vcount = HV_W'(v);
        hsync_in = hs; vsync_in = vs;
        clear_req = req; fill_code = fill;
        vis = (h < COLS*8) && (v < ROWS*8);
        a = (v / 8) * COLS + h / 8;
        re.due = cyc + 1; re.en = vis; re.addr = ADDR_W'(a);
        rdq.push_back(re);
        pe.due = cyc + 3; pe.de = vis; pe.hs = hs; pe.vs = vs; pe.pix = 1'b0;
        if (vis) begin
            row = grow(mem[a], 3'(v % 8));
            pe.pix = row[7 - (h % 8)];
        end
        pxq.push_back(pe);
        #1;
        if (char_we) begin
            wr_cnt++;
            check_eq("wr_armed", 32'(armed), 32'd1);
            check_eq("wr_in_vblank", 32'(v >= ROWS*8), 32'd1);
            check_eq("wr_rd_excl", 32'(char_rd_en), 32'd0);
            check_eq("wr_addr", 32'(char_addr), 32'(exp_wr_addr));
            check_eq("wr_data", 32'(char_wdata), 32'(exp_fill));
            exp_wr_addr++;
        end
    endtask

    initial begin
        int n, bad, wr_base;
        rst = 1'b1; hcount = '0; vcount = '0; hsync_in = 0; vsync_in = 0;
        clear_req = 0; fill_code = '0; pl_we = 0; pl_addr = '0; pl_data = '0;

        // Preload the buffer while held in reset
        for (int i = 0; i < NCELL; i++) begin
            @(negedge clk);
            pl_we = 1'b1; pl_addr = ADDR_W'(i);
            pl_data = (i == 0) ? 8'd2 : 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        pl_we = 1'b0;
        check_eq("rst_pixel_on", 32'(pixel_on), 0);
        check_eq("rst_de_out", 32'(de_out), 0);
        check_eq("rst_hsync_out", 32'(hsync_out), 0);
        check_eq("rst_vsync_out", 32'(vsync_out), 0);
        check_eq("rst_rd_en", 32'(char_rd_en), 0);
        check_eq("rst_we", 32'(char_we), 0);
        check_eq("rst_addr", 32'(char_addr), 0);
        check_eq("rst_busy", 32'(clear_busy), 0);
        check_eq("rst_done", 32'(clear_done), 0);
        rst = 1'b0;

        // Code 2 at cell 0, row 1: pattern 0,1,1,1,0,0,0,0
        for (int h = 0; h < 8; h++) step(h, 1, 0, 0, 0, 0);
        // Out of region, then a lone hsync pulse
        for (int k = 0; k < 4; k++) step(640, 1, 0, 0, 0, 0);
        step(700, 2, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(700, 2, 0, 0, 0, 0);
        // One full visible line and random beam positions
        for (int h = 0; h < COLS*8; h++) step(h, 13, 0, 0, 0, 0);
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 799), $urandom_range(0, 524),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);

        // Clear requested mid-frame: nothing written until vblank
        armed = 1'b1; exp_fill = 8'd11; exp_wr_addr = 0; wr_cnt = 0; done_cnt = 0;
        step(100, 100, 0, 0, 1, 8'd11);
        for (int k = 0; k < 30; k++) step($urandom_range(0, 639), 100 + k, 0, 0, 0, 0);
        check_eq("busy_waiting", 32'(clear_busy), 1);
        check_eq("no_wr_visible", 32'(wr_cnt), 0);
        n = 0;
        while (wr_cnt < 1000 && n < 5000) begin
            step($urandom_range(0, 799), 480 + $urandom_range(0, 44), 0, 0, 0, 0);
            n++;
        end
        check_eq("wr_count_1000", 32'(wr_cnt), 1000);
        // Vblank ends: writes pause; a second request is ignored
        for (int k = 0; k < 40; k++)
            step($urandom_range(0, 639), $urandom_range(0, 479), 0, 0, (k == 7), 8'd99);
        check_eq("wr_paused", 32'(wr_cnt), 1000);
        check_eq("busy_paused", 32'(clear_busy), 1);
        n = 0;
        while (done_cnt == 0 && n < 8000) begin
            step($urandom_range(0, 799), 480 + $urandom_range(0, 44), 0, 0, 0, 0);
            n++;
        end
        for (int k = 0; k < 6; k++) step(700, 500, 0, 0, 0, 0);
        check_eq("wr_total", 32'(wr_cnt), NCELL);
        check_eq("done_pulses", 32'(done_cnt), 1);
        check_eq("busy_after_done", 32'(clear_busy), 0);
        bad = 0;
        for (int i = 0; i < NCELL; i++) if (mem[i] !== 8'd11) bad++;
        check_eq("mem_filled", 32'(bad), 0);
        for (int k = 0; k < 50; k++) step($urandom_range(0, 799), $urandom_range(0, 524), 0, 0, 0, 0);

        // Reset in the middle of a clear abandons it at once
        armed = 1'b1; exp_fill = 8'd33; exp_wr_addr = 0; wr_base = wr_cnt;
        step(10, 10, 0, 0, 1, 8'd33);
        n = 0;
        while (wr_cnt < wr_base + 50 && n < 500) begin
            step(700, 490, 0, 0, 0, 0);
            n++;
        end
        check_eq("wr_before_rst", 32'(wr_cnt - wr_base), 50);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_we", 32'(char_we), 0);
        check_eq("rst_mid_busy", 32'(clear_busy), 0);
        check_eq("rst_mid_done", 32'(clear_done), 0);
        armed = 1'b0;
        rdq.delete();
        pxq.delete();
        @(negedge clk);
        rst = 1'b0;
        wr_base = wr_cnt;
        for (int k = 0; k < 20; k++) step(700, 490, 0, 0, 0, 0);
        check_eq("no_wr_after_rst", 32'(wr_cnt - wr_base), 0);
        check_eq("busy_after_rst", 32'(clear_busy), 0);
        for (int k = 0; k < 4; k++) step(3, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
